panel_bin_loader: RTL and testbench

- Hardware replacement for the testbench's tasks that load programs through the front panel.
- Accepts a PAL BIN-format byte stream over a valid/ready handshake and strips leader/trailer bytes.
- Decodes origin and data frames, then drives the front-panel switch, Load-PC and Deposit inputs of Top with parametrised hold timing.
- Verifies the PAL checksum, then loads the start PC and optionally asserts run.

---
 rtl/panel_bin_loader.sv | 160 ++++++++++++++++
 tb/tb_panel_bin_loader.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/panel_bin_loader.sv
// Front-panel program loader: consumes a PAL BIN byte stream and replays
// it as switch/Load-PC/Deposit actions, then verifies the checksum.
module panel_bin_loader #(
  parameter int WORD_W = 12,
  parameter int HOLD_CYCLES = 10,
  parameter logic [WORD_W-1:0] START_PC = 12'o200,
  parameter bit AUTO_RUN = 1'b1
) (
  input  logic              clk,
  input  logic              btnCpuReset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [WORD_W/2+1:0] byte_data,
  output logic              byte_ready,
  input  logic              eof,
  output logic [WORD_W-1:0] sw_out,
  output logic              load_pc,
  output logic              deposit,
  output logic              run,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

  localparam int FIELD = WORD_W / 2;
  localparam int BYTE_W = FIELD + 2;

  typedef enum logic [3:0] {
    IDLE, LEADER, HI, LO, SETUP, PULSE,
    RELEASE, FINISH, RUN_ST, DONE, ERR
  } state_t;

  state_t state, state_n;

  logic [7:0]        cnt;
  logic [BYTE_W-1:0] hi;
  logic              pend;
  logic [BYTE_W-1:0] pend_hi;
  logic [BYTE_W-1:0] pend_lo;
  logic              act_org;
  logic              act_last;
  logic [WORD_W-1:0] sum;

  logic              accept;
  logic              mark;
  logic              hold_end;
  logic [WORD_W-1:0] pend_word;

  assign byte_ready = (state == LEADER) || (state == HI) || (state == LO);
  assign accept = byte_valid && byte_ready;
  assign mark = byte_data[BYTE_W-1];
  assign hold_end = (cnt == 8'(HOLD_CYCLES - 1));
  assign pend_word = {pend_hi[FIELD-1:0], pend_lo[FIELD-1:0]};

  assign load_pc = (state == PULSE) && act_org;
  assign deposit = (state == PULSE) && !act_org;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE, ERR: if (start) state_n = LEADER;
      LEADER: begin
        if (accept && !mark) state_n = LO;
        else if (!accept && eof) state_n = ERR;
      end
      HI: begin
        if (accept) state_n = mark ? FINISH : LO;
        else if (eof) state_n = FINISH;
      end
      LO: begin
        if (accept) state_n = mark ? ERR : (pend ? SETUP : HI);
        else if (eof) state_n = ERR;
      end
      SETUP: if (hold_end) state_n = PULSE;
      PULSE: if (hold_end) state_n = RELEASE;
      RELEASE: if (hold_end) state_n = act_last ? RUN_ST : HI;
      // Checksum frame must be a data frame equal to the running sum
      FINISH: begin
        if (pend && !pend_hi[FIELD] && pend_word == sum) state_n = SETUP;
        else state_n = ERR;
      end
      RUN_ST: state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!btnCpuReset) begin
      state        <= IDLE;
      cnt          <= '0;
      hi           <= '0;
      pend         <= 1'b0;
      pend_hi      <= '0;
      pend_lo      <= '0;
      act_org      <= 1'b0;
      act_last     <= 1'b0;
      sum          <= '0;
      sw_out       <= '0;
      run          <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      state <= state_n;
      cnt <= (state_n == state) ? cnt + 8'd1 : 8'd0;
      unique case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            busy         <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            run          <= 1'b0;
            words_loaded <= '0;
            sum          <= '0;
            pend         <= 1'b0;
            act_last     <= 1'b0;
          end else if (state == ERR) begin
            busy  <= 1'b0;
            error <= 1'b1;
            run   <= 1'b0;
          end
        end
        LEADER, HI: if (accept && !mark) hi <= byte_data;
        LO: begin
          if (accept && !mark) begin
            pend    <= 1'b1;
            pend_hi <= hi;
            pend_lo <= byte_data;
            // The previous frame is only now known not to be the checksum
            if (pend) begin
              sum     <= sum + WORD_W'(pend_hi) + WORD_W'(pend_lo);
              sw_out  <= pend_word;
              act_org <= pend_hi[FIELD];
            end
          end
        end
        PULSE: begin
          if (hold_end && !act_org && words_loaded != 16'hFFFF)
            words_loaded <= words_loaded + 16'd1;
        end
        FINISH: begin
          if (state_n == SETUP) begin
            sw_out   <= START_PC;
            act_org  <= 1'b1;
            act_last <= 1'b1;
          end
        end
        RUN_ST: begin
          run  <= AUTO_RUN;
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_panel_bin_loader.sv
// Scoreboard bench for panel_bin_loader: stimulus queues expected strobes
// and final status; a negedge monitor pops and compares them.
module tb_panel_bin_loader;

  logic        clk = 1'b0;
  logic        btnCpuReset;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        eof;
  logic [11:0] sw_out;
  logic        load_pc;
  logic        deposit;
  logic        run;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  panel_bin_loader dut (
    .clk(clk),
    .btnCpuReset(btnCpuReset),
    .start(start),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .byte_ready(byte_ready),
    .eof(eof),
    .sw_out(sw_out),
    .load_pc(load_pc),
    .deposit(deposit),
    .run(run),
    .busy(busy),
    .done(done),
    .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        dep;
    logic [11:0] val;
  } strobe_t;

  typedef struct packed {
    logic        d;
    logic        e;
    logic        r;
    logic [15:0] w;
  } status_t;

  strobe_t exp_q[$];
  status_t st_q[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0o want %0o", name, act, want);
    end
  endtask

  // ---------------- monitor ----------------
  int      stable = 0;
  int      pw = 0;
  int      post_cnt = 0;
  bit      post_pend = 0;
  bit      prev_s = 0;
  bit      prev_fin = 0;
  logic [11:0] prev_sw = '0;

  always @(negedge clk) begin
    bit s;
    strobe_t ev;
    status_t st;
    if (!btnCpuReset) begin
      chk("reset_outputs",
          {16'd0, byte_ready, sw_out, load_pc, deposit, run, busy,
           done, error},
          32'd0);
      chk("reset_words", {16'd0, words_loaded}, 32'd0);
      stable = 0; pw = 0; post_pend = 0;
      prev_s = 0; prev_fin = 0; prev_sw = sw_out;
    end else begin
      if (sw_out !== prev_sw) begin
        if (post_pend) chk("sw_hold_after", post_cnt, 10);
        post_pend = 0;
        stable = 1;
      end else stable++;
      prev_sw = sw_out;
      if (post_pend) begin
        post_cnt++;
        if (post_cnt >= 10) begin
          checks++;
          post_pend = 0;
        end
      end
      s = load_pc || deposit;
      if (load_pc && deposit) chk("strobe_overlap", 1, 0);
      if (s) chk("ready_in_action", {31'd0, byte_ready}, 0);
      if (s && !prev_s) begin
        pw = 1;
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", {19'd0, deposit, sw_out}, 32'hFFFF);
        end else begin
          ev = exp_q.pop_front();
          chk("strobe_kind", {31'd0, deposit}, {31'd0, ev.dep});
          chk("strobe_value", {20'd0, sw_out}, {20'd0, ev.val});
          chk("sw_setup", (stable >= 11), 1);
        end
      end else if (s) begin
        pw++;
      end
      if (!s && prev_s) begin
        chk("pulse_width", pw, 10);
        chk("sw_during_pulse", (stable >= 21), 1);
        post_pend = 1;
        post_cnt = 1;
      end
      prev_s = s;
      if (!busy && byte_valid) chk("ready_when_idle", {31'd0, byte_ready}, 0);
      if ((done || error) && !prev_fin) begin
        chk("strobes_missing", exp_q.size(), 0);
        if (st_q.size() == 0) begin
          chk("unexpected_finish", {30'd0, done, error}, 0);
        end else begin
          st = st_q.pop_front();
          chk("fin_done", {31'd0, done}, {31'd0, st.d});
          chk("fin_error", {31'd0, error}, {31'd0, st.e});
          chk("fin_run", {31'd0, run}, {31'd0, st.r});
          chk("fin_busy", {31'd0, busy}, 0);
          chk("fin_words", {16'd0, words_loaded}, {16'd0, st.w});
        end
      end
      prev_fin = done || error;
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] good_s[$] = '{8'o200, 8'o200, 8'o102, 8'o000, 8'o072,
                            8'o001, 8'o001, 8'o075, 8'o200};
  logic [7:0] bad_s[$]  = '{8'o200, 8'o200, 8'o102, 8'o000, 8'o072,
                            8'o001, 8'o001, 8'o076, 8'o200};
  logic [7:0] trunc_s[$] = '{8'o200, 8'o102};
  logic [7:0] bp_s[$]   = '{8'o200, 8'o102, 8'o000, 8'o010, 8'o001,
                            8'o020, 8'o002, 8'o030, 8'o003, 8'o001,
                            8'o070, 8'o200};
  logic [7:0] rst_s[$]  = '{8'o200, 8'o102, 8'o000, 8'o072, 8'o001,
                            8'o001, 8'o075};
  logic [7:0] empty_s[$] = '{8'o200, 8'o200};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    bit acc;
    int t;
    acc = 0;
    t = 0;
    byte_valid = 1'b1;
    byte_data = b;
    while (!acc && t < 300) begin
      @(negedge clk);
      acc = byte_ready;
      tick();
      t++;
    end
    if (!acc) begin
      $display("FAIL byte_accept: byte %0o not taken in %0d cycles", b, t);
      $fatal(1, "byte handshake stalled");
    end
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic finish_load();
    int t;
    byte_valid = 1'b0;
    eof = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(done || error) && t < 600);
    if (!(done || error)) begin
      $display("FAIL finish_wait: done=%0b error=%0b after %0d cycles",
               done, error, t);
      $fatal(1, "load never finished");
    end
    tick();
    eof = 1'b0;
    tick();
  endtask

  task automatic exp_strobe(input logic dep, input logic [11:0] v);
    exp_q.push_back('{dep: dep, val: v});
  endtask

  task automatic exp_status(input logic d, input logic e, input logic r,
                            input logic [15:0] w);
    st_q.push_back('{d: d, e: e, r: r, w: w});
  endtask

  initial begin
    int t;
    btnCpuReset = 1'b0;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_data = '0;
    eof = 1'b0;
    repeat (3) tick();
    btnCpuReset = 1'b1;
    tick();

    // good load
    exp_strobe(0, 12'o0200);
    exp_strobe(1, 12'o7201);
    exp_strobe(0, 12'o0200);
    exp_status(1, 0, 1, 16'd1);
    pulse_start();
    foreach (good_s[i]) send(good_s[i], 2);
    finish_load();

    // bad checksum
    exp_strobe(0, 12'o0200);
    exp_strobe(1, 12'o7201);
    exp_status(0, 1, 0, 16'd1);
    pulse_start();
    foreach (bad_s[i]) send(bad_s[i], 1);
    finish_load();

    // truncated frame
    exp_status(0, 1, 0, 16'd0);
    pulse_start();
    foreach (trunc_s[i]) send(trunc_s[i], 0);
    finish_load();

    // backpressure: valid held high throughout
    exp_strobe(0, 12'o0200);
    exp_strobe(1, 12'o1001);
    exp_strobe(1, 12'o2002);
    exp_strobe(1, 12'o3003);
    exp_strobe(0, 12'o0200);
    exp_status(1, 0, 1, 16'd3);
    pulse_start();
    foreach (bp_s[i]) send(bp_s[i], 0);
    finish_load();

    // reset in the 5th cycle of a deposit pulse
    exp_strobe(0, 12'o0200);
    exp_strobe(1, 12'o7201);
    pulse_start();
    foreach (rst_s[i]) send(rst_s[i], 0);
    byte_valid = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!deposit && t < 300);
    if (!deposit) begin
      $display("FAIL deposit_wait: deposit=%0b after %0d cycles", deposit, t);
      $fatal(1, "deposit never seen");
    end
    repeat (4) @(negedge clk);
    #1 btnCpuReset = 1'b0;
    @(negedge clk);
    #1 btnCpuReset = 1'b1;
    byte_valid = 1'b1;
    byte_data = 8'o102;
    repeat (6) tick();
    byte_valid = 1'b0;
    tick();

    // empty stream, then a good load
    exp_status(0, 1, 0, 16'd0);
    pulse_start();
    foreach (empty_s[i]) send(empty_s[i], 1);
    finish_load();

    exp_strobe(0, 12'o0200);
    exp_strobe(1, 12'o7201);
    exp_strobe(0, 12'o0200);
    exp_status(1, 0, 1, 16'd1);
    pulse_start();
    foreach (good_s[i]) send(good_s[i], 0);
    finish_load();

    repeat (5) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
